multicycle_control: RTL and testbench

- Multi-cycle sequencer that sits directly upstream of the 8x8 register file.
- Fetches 16-bit instructions from an instruction ROM and decodes them.
- Drives the register file read addresses (ra1/ra2), write address (wa3), write enable (we3) and write data (wd3).
- Latches rd1/rd2, performs the ALU operation internally, and sequences PC, branch and halt.

---
 rtl/multicycle_control.sv | 161 ++++++++++++++++
 tb/tb_multicycle_control.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the 8x8 register file: fetch, decode, execute,
// writeback, with PC/branch/jump handling and a sticky halt state.
`timescale 1ns/1ps
module multicycle_control #(
  parameter int unsigned N   = 8,
  parameter int unsigned PCW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           run,
  output logic [PCW-1:0] imem_addr,
  input  logic [15:0]    imem_data,
  output logic [2:0]     ra1,
  output logic [2:0]     ra2,
  input  logic [N-1:0]   rd1,
  input  logic [N-1:0]   rd2,
  output logic [2:0]     wa3,
  output logic           we3,
  output logic [N-1:0]   wd3,
  output logic [PCW-1:0] pc,
  output logic           halted,
  output logic [2:0]     state_dbg
);

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_SLT  = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h6;
  localparam logic [3:0] OP_BEQ  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  state_t         state_q;
  logic [PCW-1:0] pc_q;
  logic [15:0]    ir_q;
  logic [N-1:0]   a_q;
  logic [N-1:0]   b_q;
  logic           we3_q;
  logic [2:0]     wa3_q;
  logic [N-1:0]   wd3_q;  // holds ALUOut for the writeback cycle
  logic           halted_q;

  logic [3:0]     op;
  logic [2:0]     rd;
  logic [2:0]     rs1;
  logic [2:0]     rs2;
  logic [N-1:0]   imm_n;
  logic [PCW-1:0] imm_pc;
  logic [N-1:0]   alu_d;
  logic           is_alu;

  assign op     = ir_q[15:12];
  assign rd     = ir_q[11:9];
  assign rs1    = ir_q[8:6];
  assign rs2    = ir_q[5:3];
  assign imm_n  = {{(N-6){ir_q[5]}}, ir_q[5:0]};
  assign imm_pc = {{(PCW-6){ir_q[5]}}, ir_q[5:0]};
  assign is_alu = (op != 4'h0) && (op <= OP_ADDI);

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign we3       = we3_q;
  assign wa3       = wa3_q;
  assign wd3       = wd3_q;
  assign halted    = halted_q;
  assign state_dbg = state_q;

  // Register file read ports; BEQ compares R[rd] against R[rs1]
  always_comb begin
    ra1 = rs1;
    ra2 = rs2;
    if (op == OP_BEQ) begin
      ra1 = rd;
      ra2 = rs1;
    end
  end

  // ALU result from the latched operands, modulo 2^N
  always_comb begin
    alu_d = '0;
    case (op)
      OP_ADD:  alu_d = a_q + b_q;
      OP_SUB:  alu_d = a_q - b_q;
      OP_AND:  alu_d = a_q & b_q;
      OP_OR:   alu_d = a_q | b_q;
      OP_SLT:  alu_d = ($signed(a_q) < $signed(b_q)) ? N'(1) : '0;
      OP_ADDI: alu_d = a_q + imm_n;
      default: alu_d = '0;
    endcase
  end

  // Sequencer state, PC, instruction/operand latches and registered write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      we3_q    <= 1'b0;
      wa3_q    <= '0;
      wd3_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (run) state_q <= S_FETCH;
        end
        S_FETCH: begin
          ir_q    <= imem_data;
          pc_q    <= pc_q + PCW'(1);
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          a_q     <= rd1;
          b_q     <= rd2;
          state_q <= S_EXECUTE;
        end
        S_EXECUTE: begin
          if (is_alu) begin
            we3_q   <= (rd != 3'd0);
            wa3_q   <= rd;
            wd3_q   <= alu_d;
            state_q <= S_WRITEBACK;
          end else if (op == OP_HALT) begin
            halted_q <= 1'b1;
            state_q  <= S_HALT;
          end else begin
            if ((op == OP_BEQ) && (a_q == b_q)) pc_q <= pc_q + imm_pc;
            if (op == OP_JMP) pc_q <= PCW'(ir_q[7:0]);
            state_q <= run ? S_FETCH : S_IDLE;
          end
        end
        S_WRITEBACK: begin
          we3_q   <= 1'b0;
          wa3_q   <= '0;
          wd3_q   <= '0;
          state_q <= run ? S_FETCH : S_IDLE;
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction-level reference model feeds an
// expected-write queue; a negedge monitor pops and compares register writes.
`timescale 1ns/1ps
module tb_multicycle_control;

  logic        clk;
  logic        rst;
  logic        run;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic [2:0]  ra1;
  logic [2:0]  ra2;
  logic [7:0]  rd1;
  logic [7:0]  rd2;
  logic [2:0]  wa3;
  logic        we3;
  logic [7:0]  wd3;
  logic [7:0]  pc;
  logic        halted;
  logic [2:0]  state_dbg;

  multicycle_control #(.N(8), .PCW(8)) dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .wa3(wa3), .we3(we3), .wd3(wd3),
    .pc(pc), .halted(halted), .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction ROM and register file behaviour around the DUT
  logic [15:0] rom [256];
  logic [7:0]  rf  [8];
  logic        rf_clr;

  assign imem_data = rom[imem_addr];
  assign rd1 = rf[ra1];
  assign rd2 = rf[ra2];

  always @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 8; i++) rf[i] <= 8'd0;
    end else if (we3 === 1'b1) begin
      rf[wa3] <= wd3;
    end
  end

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        exp_q [$];
  wr_t        mon_e;
  logic [7:0] mreg  [8];
  logic [7:0] mpc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int sval(input logic [7:0] x);
    return x[7] ? int'(x) - 256 : int'(x);
  endfunction

  // Monitor: every write the DUT presents must match the next expected one
  always @(negedge clk) begin
    if (we3 === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=%0d:%0h required=none", wa3, wd3);
      end else begin
        mon_e = exp_q.pop_front();
        chk("write_addr", 32'(wa3), 32'(mon_e.a));
        chk("write_data", 32'(wd3), 32'(mon_e.d));
      end
    end else if (rst === 1'b0) begin
      chk("quiet_wa3", 32'(wa3), 32'd0);
      if (state_dbg !== 3'd4) chk("quiet_wd3", 32'(wd3), 32'd0);
    end
  end

  // Instruction-level model: runs up to max_instr instructions from pc 0,
  // queues expected writes and returns the clock edges the DUT should take.
  task automatic model_run(input int max_instr, output int edges, output bit hit_halt);
    logic [15:0] ins;
    logic [3:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  res;
    int          simm;
    bit          alu;
    wr_t         w;
    edges    = 1;
    hit_halt = 1'b0;
    mpc      = 8'd0;
    for (int i = 0; i < 8; i++) mreg[i] = 8'd0;
    for (int k = 0; k < max_instr && !hit_halt; k++) begin
      ins  = rom[mpc];
      mpc  = 8'(int'(mpc) + 1);
      op   = ins[15:12];
      rd   = ins[11:9];
      rs1  = ins[8:6];
      rs2  = ins[5:3];
      simm = ins[5] ? int'(ins[5:0]) - 64 : int'(ins[5:0]);
      a    = mreg[rs1];
      b    = mreg[rs2];
      alu  = 1'b1;
      res  = 8'd0;
      case (op)
        4'h1:    res = 8'(int'(a) + int'(b));
        4'h2:    res = 8'(int'(a) - int'(b));
        4'h3:    res = a & b;
        4'h4:    res = a | b;
        4'h5:    res = (sval(a) < sval(b)) ? 8'd1 : 8'd0;
        4'h6:    res = 8'(int'(a) + simm);
        default: alu = 1'b0;
      endcase
      if (alu) begin
        edges += 4;
        if (rd != 3'd0) begin
          mreg[rd] = res;
          w.a = rd;
          w.d = res;
          exp_q.push_back(w);
        end
      end else begin
        edges += 3;
        if (op == 4'h7 && mreg[rd] == mreg[rs1]) mpc = 8'(int'(mpc) + simm);
        if (op == 4'h8) mpc = ins[7:0];
        if (op == 4'hF) hit_halt = 1'b1;
      end
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    run    = 1'b0;
    rf_clr = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rf_clr = 1'b0;
    rst    = 1'b0;
  endtask

  // Runs the ROM program to HALT (or max_instr instructions) and checks the end state
  task automatic run_prog(input string name, input int max_instr);
    int edges;
    bit hh;
    int n;
    do_reset();
    model_run(max_instr, edges, hh);
    run = 1'b1;
    if (hh) begin
      n = 0;
      while (halted !== 1'b1 && n < 600) begin
        @(posedge clk);
        n++;
        @(negedge clk);
      end
      chk({name, "_edges_to_halt"}, 32'(n), 32'(edges));
      chk({name, "_halt_state"}, 32'(state_dbg), 32'd5);
      chk({name, "_halt_pc"}, 32'(pc), 32'(mpc));
      for (int i = 0; i < 4; i++) begin
        run = ~run;
        @(negedge clk);
        chk({name, "_halt_sticky"}, 32'(halted), 32'd1);
      end
    end else begin
      repeat (edges) @(posedge clk);
      @(negedge clk);
      chk({name, "_end_state"}, 32'(state_dbg), 32'd1);
      chk({name, "_end_pc"}, 32'(pc), 32'(mpc));
    end
    chk({name, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    for (int i = 1; i < 8; i++) chk({name, "_regfile"}, 32'(rf[i]), 32'(mreg[i]));
    run = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int         n;
    int         edges;
    bit         hh;
    int         r;
    logic [3:0] op;

    rst    = 1'b1;
    run    = 1'b0;
    rf_clr = 1'b1;
    clear_rom();

    // Reset and idle with run low
    do_reset();
    repeat (10) @(negedge clk);
    chk("idle_state", 32'(state_dbg), 32'd0);
    chk("idle_pc", 32'(pc), 32'd0);
    chk("idle_imem_addr", 32'(imem_addr), 32'd0);
    chk("idle_we3", 32'(we3), 32'd0);
    chk("idle_halted", 32'(halted), 32'd0);

    // ADDI then ADD, then HALT
    clear_rom();
    rom[0] = 16'h6205;
    rom[1] = 16'h6443;
    rom[2] = 16'h1650;
    rom[3] = 16'hF000;
    run_prog("addi_add", 1000);

    // SUB / SLT signed
    clear_rom();
    rom[0] = 16'h6203;
    rom[1] = 16'h6405;
    rom[2] = 16'h2850;
    rom[3] = 16'h5B08;
    rom[4] = 16'hF000;
    run_prog("sub_slt", 1000);

    // Writes to R0 are suppressed; R0 reads back zero
    clear_rom();
    rom[0] = 16'h6007;
    rom[1] = 16'h1C00;
    rom[2] = 16'hF000;
    run_prog("r0_suppress", 1000);

    // Taken backward BEQ lands on HALT
    clear_rom();
    rom[0] = 16'h8004;
    rom[3] = 16'hF000;
    rom[4] = 16'h703E;
    run_prog("beq_back", 1000);

    // JMP to 0xFF, then increment wraps to 0x00
    clear_rom();
    rom[0] = 16'h80FF;
    run_prog("jmp_ff", 1);
    run_prog("jmp_wrap", 2);

    // Drop run during DECODE of an ADD, then resume
    clear_rom();
    rom[0] = 16'h6205;
    rom[1] = 16'h1448;
    rom[2] = 16'h1688;
    rom[3] = 16'hF000;
    do_reset();
    model_run(1000, edges, hh);
    run = 1'b1;
    n = 0;
    while (!(state_dbg === 3'd2 && pc === 8'd2) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rundrop_reach_decode", 32'(state_dbg), 32'd2);
    run = 1'b0;
    n = 0;
    while (state_dbg !== 3'd0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rundrop_idle", 32'(state_dbg), 32'd0);
    chk("rundrop_pc", 32'(pc), 32'd2);
    chk("rundrop_pending", 32'(exp_q.size()), 32'd1);
    repeat (3) @(negedge clk);
    chk("rundrop_parked", 32'(state_dbg), 32'd0);
    run = 1'b1;
    n = 0;
    while (halted !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("resume_halted", 32'(halted), 32'd1);
    chk("resume_pending", 32'(exp_q.size()), 32'd0);
    chk("resume_r3", 32'(rf[3]), 32'(mreg[3]));
    run = 1'b0;

    // Async reset during WRITEBACK aborts the write without a clock edge
    clear_rom();
    rom[0] = 16'h6205;
    do_reset();
    model_run(1, edges, hh);
    run = 1'b1;
    n = 0;
    while (state_dbg !== 3'd4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("arst_reach_wb", 32'(state_dbg), 32'd4);
    chk("arst_we3_before", 32'(we3), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_we3_after", 32'(we3), 32'd0);
    chk("arst_pc", 32'(pc), 32'd0);
    chk("arst_state", 32'(state_dbg), 32'd0);
    @(negedge clk);
    chk("arst_no_write", 32'(rf[1]), 32'd0);
    run = 1'b0;

    // Random programs over the whole ROM
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 256; i++) begin
        r  = int'($urandom_range(0, 19));
        op = (r < 15) ? 4'(r) : 4'h6;
        rom[i] = {op, 12'($urandom)};
      end
      run_prog("random", 40);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
